iq_comp_settle_fsm: RTL and testbench
=====================================

// Module: iq_comp_settle_fsm
// PURPOSE
//  Start-signal controller upstream of iq_comp: drives its freeze_iqcomp input and consumes its Wr/Wj debug outputs.
//  After a start request, it lets iq_comp adapt for a warm-up period, then watches Wr/Wj until both stay within tolerance
//  for a run of cycles. It then freezes adaptation, captures the settled W and flags settled so the MCU can store W.
//  A timeout forces the freeze if W never settles.
// PARAMETERS
//  W_WIDTH        13     width of signed Wr/Wj
//  CNT_WIDTH      16     width of all internal counters
//  WARMUP_CYCLES  1024   cycles spent in WARMUP before tracking starts (>=1)
//  STABLE_CYCLES  256    consecutive in-tolerance cycles needed to lock (>=1)
//  TOL            8      max |W - W_ref| per component counted as stable (unsigned)
//  TIMEOUT_CYCLES 65535  max cycles from WARMUP entry before a forced freeze (>WARMUP_CYCLES)
// PORTS
//  clk            in   1        system clock; all logic on posedge
//  RESETn         in   1        synchronous active-low reset
//  start          in   1        level-sampled request to (re)start adaptation; acted on in IDLE or LOCKED
//  abort          in   1        return to IDLE from any state
//  Wr             in   W_WIDTH  signed, from iq_comp Wr
//  Wj             in   W_WIDTH  signed, from iq_comp Wj
//  freeze_iqcomp  out  1        to iq_comp; 1 = hold W, 0 = adapt
//  settled        out  1        1 while LOCKED after a genuine lock
//  timeout        out  1        1 while LOCKED after a forced (timeout) freeze
//  Wr_hold        out  W_WIDTH  Wr captured at lock/timeout
//  Wj_hold        out  W_WIDTH  Wj captured at lock/timeout
//  state          out  2        IDLE=0, WARMUP=1, TRACK=2, LOCKED=3
// BEHAVIOUR
//  - Reset (RESETn=0 at posedge): state=IDLE, freeze_iqcomp=1, settled=0, timeout=0, Wr_hold=Wj_hold=0, counters=0, refs=0.
//  - All outputs are registered Moore outputs. freeze_iqcomp=1 in IDLE and LOCKED, and 0 in WARMUP and TRACK.
//  - Priority per cycle: abort > start > lock > timeout > normal advance.
//  - IDLE: start=1 -> WARMUP next cycle; clear warm_cnt, stable_cnt, tot_cnt, settled, timeout.
//  - WARMUP: stays exactly WARMUP_CYCLES cycles, with warm_cnt counting 0..WARMUP_CYCLES-1.
//    On the last cycle: ref_r<=Wr, ref_j<=Wj, stable_cnt<=0, go to TRACK.
//  - TRACK, per cycle:
//    - dr=Wr-ref_r and dj=Wj-ref_j, computed at W_WIDTH+1 bits (no overflow); abs values compared to TOL.
//    - Both |dr|<=TOL and |dj|<=TOL: if stable_cnt==STABLE_CYCLES-1, go to LOCKED with Wr_hold<=Wr, Wj_hold<=Wj, settled<=1.
//      Otherwise stable_cnt++.
//    - Either component out of tolerance: ref<=current W, stable_cnt<=0.
//  - tot_cnt counts every cycle in WARMUP and TRACK from WARMUP entry, saturating at max.
//    On the cycle where tot_cnt==TIMEOUT_CYCLES-1 and no lock occurs: go to LOCKED, capture W_hold, timeout<=1, settled<=0.
//    Lock and timeout in the same cycle -> lock wins (settled=1, timeout=0).
//  - LOCKED: holds W_hold/flags. start=1 -> WARMUP (re-adapt): flags clear, W_hold retained until the next capture.
//  - abort=1 in any state -> IDLE next cycle, freeze=1, flags cleared, W_hold retained.
//  - Reset mid-operation overrides everything (same values as reset above).
//  - start held high in WARMUP/TRACK is ignored (no restart); only abort interrupts adaptation.
// TESTING (bench params: WARMUP=4, STABLE=3, TOL=2, TIMEOUT=20)
//  1 Reset then idle: RESETn=0 for 2 clk -> state=0, freeze=1, settled=0, timeout=0, Wr_hold=Wj_hold=0.
//  2 Lock: start pulse, Wr=100, Wj=-50 constant -> freeze=0 for 4+3 cycles, then state=3, freeze=1, settled=1, Wr_hold=100, Wj_hold=-50.
//  3 Tolerance: in TRACK, Wr steps 100,102,99 -> the 99 (|dr|=1 vs ref 100) counts; then Wr=103 (|dr|=3) resets stable_cnt and ref_r=103.
//  4 Timeout: Wr toggles 0/+10 every cycle -> never stable; 20 cycles after WARMUP entry state=3, timeout=1, settled=0, Wr_hold = last Wr.
//  5 Abort/restart: abort during TRACK -> IDLE next cycle, freeze=1; start in LOCKED -> WARMUP, flags cleared, W_hold kept.
//  6 Edge widths: Wr=+4095 with ref=-4096 -> no overflow, out of tolerance; simultaneous lock and timeout cycle -> settled=1, timeout=0.

Source files
------------

// File: rtl/iq_comp_settle_fsm.sv
// Settling controller for iq_comp: lets W adapt, waits for Wr/Wj to stay inside a
// tolerance window for a run of cycles, then freezes adaptation and captures W.
module iq_comp_settle_fsm #(
    parameter int W_WIDTH        = 13,
    parameter int CNT_WIDTH      = 16,
    parameter int WARMUP_CYCLES  = 1024,
    parameter int STABLE_CYCLES  = 256,
    parameter int TOL            = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      RESETn,
    input  logic                      start,
    input  logic                      abort,
    input  logic signed [W_WIDTH-1:0] Wr,
    input  logic signed [W_WIDTH-1:0] Wj,
    output logic                      freeze_iqcomp,
    output logic                      settled,
    output logic                      timeout,
    output logic signed [W_WIDTH-1:0] Wr_hold,
    output logic signed [W_WIDTH-1:0] Wj_hold,
    output logic [1:0]                state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] WARM_LAST   = CNT_WIDTH'(WARMUP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TO_LAST     = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [W_WIDTH:0]     TOL_W       = (W_WIDTH+1)'(TOL);

    // The difference is taken one bit wider than W so full-scale swings cannot wrap.
    function automatic logic within_tol(input logic [W_WIDTH-1:0] cur,
                                        input logic [W_WIDTH-1:0] ref_v);
        logic [W_WIDTH:0] diff;
        logic [W_WIDTH:0] mag;
        diff = {cur[W_WIDTH-1], cur} - {ref_v[W_WIDTH-1], ref_v};
        mag  = diff[W_WIDTH] ? (~diff + {{W_WIDTH{1'b0}}, 1'b1}) : diff;
        return (mag <= TOL_W);
    endfunction

    state_t                     state_r, state_s;
    logic                       freeze_r, freeze_s;
    logic                       settled_r, settled_s;
    logic                       timeout_r, timeout_s;
    logic        [CNT_WIDTH-1:0] warm_cnt_r, warm_cnt_s;
    logic        [CNT_WIDTH-1:0] stable_cnt_r, stable_cnt_s;
    logic        [CNT_WIDTH-1:0] tot_cnt_r, tot_cnt_s;
    logic signed [W_WIDTH-1:0]  ref_r_r, ref_r_s;
    logic signed [W_WIDTH-1:0]  ref_j_r, ref_j_s;
    logic signed [W_WIDTH-1:0]  wr_hold_r, wr_hold_s;
    logic signed [W_WIDTH-1:0]  wj_hold_r, wj_hold_s;
    logic                       in_tol_s;
    logic                       to_hit_s;
    logic        [CNT_WIDTH-1:0] tot_inc_s;

    // Tolerance check, timeout condition and saturating total-cycle increment.
    always_comb begin
        in_tol_s  = within_tol(Wr, ref_r_r) && within_tol(Wj, ref_j_r);
        to_hit_s  = (tot_cnt_r == TO_LAST);
        if (tot_cnt_r == CNT_MAX) begin
            tot_inc_s = tot_cnt_r;
        end else begin
            tot_inc_s = tot_cnt_r + CNT_ONE;
        end
    end

    // Next-state and next-register logic; priority abort > start > lock > timeout > advance.
    always_comb begin
        state_s      = state_r;
        settled_s    = settled_r;
        timeout_s    = timeout_r;
        warm_cnt_s   = warm_cnt_r;
        stable_cnt_s = stable_cnt_r;
        tot_cnt_s    = tot_cnt_r;
        ref_r_s      = ref_r_r;
        ref_j_s      = ref_j_r;
        wr_hold_s    = wr_hold_r;
        wj_hold_s    = wj_hold_r;
        if (abort) begin
            state_s   = IDLE;
            settled_s = 1'b0;
            timeout_s = 1'b0;
        end else begin
            case (state_r)
                IDLE, LOCKED: begin
                    if (start) begin
                        state_s      = WARMUP;
                        warm_cnt_s   = '0;
                        stable_cnt_s = '0;
                        tot_cnt_s    = '0;
                        settled_s    = 1'b0;
                        timeout_s    = 1'b0;
                    end else begin
                        state_s = state_r;
                    end
                end
                WARMUP: begin
                    tot_cnt_s = tot_inc_s;
                    if (to_hit_s) begin
                        state_s   = LOCKED;
                        wr_hold_s = Wr;
                        wj_hold_s = Wj;
                        timeout_s = 1'b1;
                        settled_s = 1'b0;
                    end else if (warm_cnt_r == WARM_LAST) begin
                        state_s      = TRACK;
                        ref_r_s      = Wr;
                        ref_j_s      = Wj;
                        stable_cnt_s = '0;
                    end else begin
                        warm_cnt_s = warm_cnt_r + CNT_ONE;
                    end
                end
                TRACK: begin
                    tot_cnt_s = tot_inc_s;
                    if (in_tol_s && (stable_cnt_r == STABLE_LAST)) begin
                        state_s   = LOCKED;
                        wr_hold_s = Wr;
                        wj_hold_s = Wj;
                        settled_s = 1'b1;
                        timeout_s = 1'b0;
                    end else begin
                        if (in_tol_s) begin
                            stable_cnt_s = stable_cnt_r + CNT_ONE;
                        end else begin
                            ref_r_s      = Wr;
                            ref_j_s      = Wj;
                            stable_cnt_s = '0;
                        end
                        if (to_hit_s) begin
                            state_s   = LOCKED;
                            wr_hold_s = Wr;
                            wj_hold_s = Wj;
                            timeout_s = 1'b1;
                            settled_s = 1'b0;
                        end else begin
                            state_s = TRACK;
                        end
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
        freeze_s = (state_s == IDLE) || (state_s == LOCKED);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!RESETn) begin
            state_r      <= IDLE;
            freeze_r     <= 1'b1;
            settled_r    <= 1'b0;
            timeout_r    <= 1'b0;
            warm_cnt_r   <= '0;
            stable_cnt_r <= '0;
            tot_cnt_r    <= '0;
            ref_r_r      <= '0;
            ref_j_r      <= '0;
            wr_hold_r    <= '0;
            wj_hold_r    <= '0;
        end else begin
            state_r      <= state_s;
            freeze_r     <= freeze_s;
            settled_r    <= settled_s;
            timeout_r    <= timeout_s;
            warm_cnt_r   <= warm_cnt_s;
            stable_cnt_r <= stable_cnt_s;
            tot_cnt_r    <= tot_cnt_s;
            ref_r_r      <= ref_r_s;
            ref_j_r      <= ref_j_s;
            wr_hold_r    <= wr_hold_s;
            wj_hold_r    <= wj_hold_s;
        end
    end

    assign freeze_iqcomp = freeze_r;
    assign settled       = settled_r;
    assign timeout       = timeout_r;
    assign Wr_hold       = wr_hold_r;
    assign Wj_hold       = wj_hold_r;
    assign state         = state_r;

endmodule

// File: tb/tb_iq_comp_settle_fsm.sv
// Directed vector bench for iq_comp_settle_fsm with WARMUP=4, STABLE=3, TOL=2, TIMEOUT=20.
module tb_iq_comp_settle_fsm;

    logic               clk;
    logic               rstn;
    logic               start;
    logic               abort;
    logic signed [12:0] wr;
    logic signed [12:0] wj;
    logic               freeze;
    logic               settled;
    logic               timeout;
    logic signed [12:0] wr_hold;
    logic signed [12:0] wj_hold;
    logic [1:0]         state;

    int n_vec;
    int n_bad;

    typedef struct {
        logic               rstn;
        logic               start;
        logic               abort;
        logic signed [12:0] wr;
        logic signed [12:0] wj;
        logic [1:0]         st;
        logic               fr;
        logic               se;
        logic               to;
        logic signed [12:0] wh;
        logic signed [12:0] jh;
    } vec_t;

    vec_t tbl[$];

    iq_comp_settle_fsm #(
        .W_WIDTH(13), .CNT_WIDTH(16), .WARMUP_CYCLES(4),
        .STABLE_CYCLES(3), .TOL(2), .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk), .RESETn(rstn), .start(start), .abort(abort),
        .Wr(wr), .Wj(wj), .freeze_iqcomp(freeze), .settled(settled),
        .timeout(timeout), .Wr_hold(wr_hold), .Wj_hold(wj_hold), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input int r, input int s, input int a, input int xr, input int xj,
                       input int st, input int fr, input int se, input int to,
                       input int wh, input int jh);
        vec_t v;
        v.rstn = r[0]; v.start = s[0]; v.abort = a[0];
        v.wr = 13'(xr); v.wj = 13'(xj);
        v.st = 2'(st); v.fr = fr[0]; v.se = se[0]; v.to = to[0];
        v.wh = 13'(wh); v.jh = 13'(jh);
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs, then compare all outputs #1 after the edge.
    task automatic step(input string name, input int r, input int s, input int a,
                        input int xr, input int xj, input int st, input int fr,
                        input int se, input int to, input int wh, input int jh);
        logic signed [12:0] ewh;
        logic signed [12:0] ejh;
        ewh = 13'(wh);
        ejh = 13'(jh);
        rstn = r[0]; start = s[0]; abort = a[0];
        wr = 13'(xr); wj = 13'(xj);
        @(posedge clk);
        #1;
        n_vec++;
        if (state !== 2'(st) || freeze !== fr[0] || settled !== se[0] || timeout !== to[0] ||
            wr_hold !== ewh || wj_hold !== ejh) begin
            n_bad++;
            $display("FAIL %s #%0d: got st=%0d fr=%0b se=%0b to=%0b wh=%0d jh=%0d, want st=%0d fr=%0d se=%0d to=%0d wh=%0d jh=%0d",
                     name, n_vec, state, freeze, settled, timeout, wr_hold, wj_hold,
                     st, fr, se, to, ewh, ejh);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rstn = 1'b0; start = 1'b0; abort = 1'b0; wr = '0; wj = '0;

        // Reset and idle
        add(0,0,0,0,0,       0,1,0,0,0,0);
        add(0,0,0,0,0,       0,1,0,0,0,0);
        add(1,0,0,0,0,       0,1,0,0,0,0);
        // Lock on constant W after 4 warm-up + 3 stable cycles
        add(1,1,0,100,-50,   1,0,0,0,0,0);
        for (int i = 0; i < 3; i++) add(1,0,0,100,-50, 1,0,0,0,0,0);
        for (int i = 0; i < 3; i++) add(1,0,0,100,-50, 2,0,0,0,0,0);
        add(1,0,0,100,-50,   3,1,1,0,100,-50);
        add(1,0,0,100,-50,   3,1,1,0,100,-50);
        // Restart from LOCKED, tolerance window edges
        add(1,1,0,100,0,     1,0,0,0,100,-50);
        for (int i = 0; i < 3; i++) add(1,0,0,100,0, 1,0,0,0,100,-50);
        add(1,0,0,100,0,     2,0,0,0,100,-50);
        add(1,0,0,102,0,     2,0,0,0,100,-50);
        add(1,0,0,99,0,      2,0,0,0,100,-50);
        add(1,0,0,103,0,     2,0,0,0,100,-50);
        add(1,0,0,101,0,     2,0,0,0,100,-50);
        add(1,0,0,105,0,     2,0,0,0,100,-50);
        add(1,0,0,104,0,     3,1,1,0,104,0);

        for (int i = 0; i < tbl.size(); i++) begin
            step("tbl", tbl[i].rstn, tbl[i].start, tbl[i].abort, tbl[i].wr, tbl[i].wj,
                 tbl[i].st, tbl[i].fr, tbl[i].se, tbl[i].to, tbl[i].wh, tbl[i].jh);
        end

        // Abort during TRACK; abort outranks start in IDLE
        step("abort_go", 1,1,0,0,0, 1,0,0,0,104,0);
        for (int i = 0; i < 3; i++) step("abort_warm", 1,0,0,0,0, 1,0,0,0,104,0);
        step("abort_trk", 1,0,0,0,0, 2,0,0,0,104,0);
        step("abort",     1,1,1,0,0, 0,1,0,0,104,0);
        step("abort_idle",1,1,1,0,0, 0,1,0,0,104,0);

        // Timeout: W toggles every cycle, start held high throughout adaptation
        for (int k = 1; k <= 21; k++) begin
            if (k <= 4)       step("to_warm", 1,1,0,(k%2)?10:0,7, 1,0,0,0,104,0);
            else if (k <= 20) step("to_trk",  1,1,0,(k%2)?10:0,7, 2,0,0,0,104,0);
            else              step("timeout", 1,1,0,(k%2)?10:0,7, 3,1,0,1,10,7);
        end
        step("to_hold", 1,0,0,0,0, 3,1,0,1,10,7);

        // Full-scale step: 4095 against ref -4096 must not wrap into tolerance
        step("ovf_go", 1,1,0,-4096,0, 1,0,0,0,10,7);
        for (int i = 0; i < 3; i++) step("ovf_warm", 1,0,0,-4096,0, 1,0,0,0,10,7);
        step("ovf_ref", 1,0,0,-4096,0, 2,0,0,0,10,7);
        for (int i = 0; i < 3; i++) step("ovf_trk", 1,0,0,4095,0, 2,0,0,0,10,7);
        step("ovf_lock", 1,0,0,4095,0, 3,1,1,0,4095,0);

        // Lock lands on the timeout cycle: lock wins
        for (int k = 1; k <= 21; k++) begin
            if (k <= 4)       step("both_warm", 1,(k==1)?1:0,0,(k<=18 && k%2==1)?10:0,3, 1,0,0,0,4095,0);
            else if (k <= 20) step("both_trk",  1,0,0,(k<=18 && k%2==1)?10:0,3, 2,0,0,0,4095,0);
            else              step("both_lock", 1,0,0,0,3, 3,1,1,0,0,3);
        end

        // Reset in the middle of WARMUP
        step("rst_go",   1,1,0,5,5, 1,0,0,0,0,3);
        step("rst_mid",  0,0,0,5,5, 0,1,0,0,0,0);
        step("rst_idle", 1,0,0,5,5, 0,1,0,0,0,0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
